edf_irq_responder: RTL

Core-side responder for the EDF interrupt controller's request/acknowledge handshake. It accepts an interrupt ID offered on `irq_req_i`/`irq_id_i`, returns a one-cycle `irq_ack_i`-style pulse on `irq_ack_o`, and presents the pending interrupt to the core. It tracks nested active interrupts in a claim/complete stack and measures accept-to-claim latency for deadline analysis. It sits between the controller's request port and the hart's interrupt inputs.

---
 rtl/edf_irq_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/edf_irq_responder.sv
// Core-side responder for the EDF interrupt controller: accepts and acknowledges a request,
// presents it to the core, tracks claimed-but-not-completed IDs on a stack, and measures claim latency.
module edf_irq_responder #(
    parameter int IrqIdWidth = 8,
    parameter int NestDepth  = 4,
    parameter int LatWidth   = 16,
    localparam int DepthWidth = $clog2(NestDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_req_i,
    input  logic [IrqIdWidth-1:0] irq_id_i,
    output logic                  irq_ack_o,
    input  logic                  core_irq_en_i,
    output logic                  core_irq_o,
    output logic [IrqIdWidth-1:0] core_irq_id_o,
    input  logic                  core_claim_i,
    input  logic                  core_complete_i,
    input  logic [IrqIdWidth-1:0] core_complete_id_i,
    output logic                  active_valid_o,
    output logic [IrqIdWidth-1:0] active_id_o,
    output logic [DepthWidth-1:0] depth_o,
    output logic                  complete_err_o,
    output logic [LatWidth-1:0]   latency_o,
    output logic                  latency_valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        PEND
    } state_e;

    localparam logic [DepthWidth-1:0] Full = DepthWidth'(NestDepth);

    state_e                  state_q, state_d;
    logic [IrqIdWidth-1:0]   pend_id_q;
    logic [LatWidth-1:0]     lat_cnt_q;
    logic [DepthWidth-1:0]   depth_q;
    // Shift stack: entry 0 is always the top of stack.
    logic [IrqIdWidth-1:0]   stack_q [NestDepth];

    logic accept, claim, pop, cmp_err, non_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        claim         = 1'b0;
        irq_ack_o     = 1'b0;
        core_irq_o    = 1'b0;
        core_irq_id_o = '0;
        unique case (state_q)
            IDLE: begin
                if (irq_req_i && core_irq_en_i && depth_q != Full) begin
                    accept  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                irq_ack_o = 1'b1;
                state_d   = PEND;
            end
            PEND: begin
                core_irq_o    = 1'b1;
                core_irq_id_o = pend_id_q;
                if (core_claim_i) begin
                    claim   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign non_empty = (depth_q != '0);
    assign pop       = core_complete_i && non_empty && (core_complete_id_i == stack_q[0]);
    assign cmp_err   = core_complete_i && !pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_id_q       <= '0;
            lat_cnt_q       <= '0;
            depth_q         <= '0;
            latency_o       <= '0;
            latency_valid_o <= 1'b0;
            complete_err_o  <= 1'b0;
        end else begin
            latency_valid_o <= claim;
            complete_err_o  <= cmp_err;
            if (accept) begin
                pend_id_q <= irq_id_i;
                lat_cnt_q <= LatWidth'(1);
            end else if (state_q != IDLE && lat_cnt_q != '1) begin
                lat_cnt_q <= lat_cnt_q + LatWidth'(1);
            end
            if (claim) latency_o <= lat_cnt_q;
            depth_q <= depth_q + DepthWidth'(claim) - DepthWidth'(pop);
        end
    end

    // NOTE: stack storage has no reset; depth_q alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (claim && pop) begin
            stack_q[0] <= pend_id_q;
        end else if (claim) begin
            for (int i = NestDepth - 1; i > 0; i--) stack_q[i] <= stack_q[i-1];
            stack_q[0] <= pend_id_q;
        end else if (pop) begin
            for (int i = 0; i < NestDepth - 1; i++) stack_q[i] <= stack_q[i+1];
        end
    end

    assign active_valid_o = non_empty;
    assign active_id_o    = non_empty ? stack_q[0] : '0;
    assign depth_o        = depth_q;

endmodule
